// File: rtl/fns_pkg.sv
// Shared helpers for the Fibonacci-numeral-system decoder: digit weights,
// exact sum width and a configuration sanity check.
package fns_pkg;

  // w[0]=1, w[1]=2, w[i]=w[i-1]+w[i-2]
  function automatic int unsigned fns_weight(input int unsigned i);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 2;
    for (int unsigned k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // The all-ones codeword sums to w[cw+1]-2, so this width never truncates.
  function automatic int unsigned fns_sum_width(input int unsigned cw);
    return $clog2(fns_weight(cw + 1) - 1);
  endfunction

  function automatic bit fns_cfg_ok(input int unsigned cw, input int unsigned group,
                                    input int unsigned dw);
    return (cw >= 2) && (group >= 1) && ((cw % group) == 0) && (dw >= 1);
  endfunction

endpackage

// File: rtl/fns_dec_pipe_if.sv
// Codeword-in / data-out stream pair of the FNS decoder, one shared handshake per side.
interface fns_dec_pipe_if #(
  parameter int LANES = 1,
  parameter int CW    = 16,
  parameter int DW    = 13
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*CW-1:0]   codein;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   dataout;
  logic [LANES-1:0]      out_err;

  modport master (
    output in_valid, codein, out_ready,
    input  in_ready, out_valid, dataout, out_err
  );

  modport slave (
    input  in_valid, codein, out_ready,
    output in_ready, out_valid, dataout, out_err
  );
endinterface

// File: rtl/fns_partial_sum.sv
// Combinational weighted sum of GROUP consecutive codeword bits starting at bit BASE.
module fns_partial_sum
  import fns_pkg::*;
#(
  parameter int GROUP = 4,
  parameter int BASE  = 0,
  parameter int SW    = 13
) (
  input  logic [GROUP-1:0] bits,
  output logic [SW-1:0]    psum
);

  always_comb begin
    psum = '0;
    for (int i = 0; i < GROUP; i++) begin
      if (bits[i]) psum = psum + SW'(fns_weight(unsigned'(BASE + i)));
    end
  end

endmodule

// File: rtl/fns_dec_pipe.sv
// Two-stage streaming FNS decoder: S1 registers per-group partial sums, S2 registers
// the lane totals with overflow flags; a saturating counter tallies flagged lanes.
module fns_dec_pipe
  import fns_pkg::*;
#(
  parameter int CW    = 16,
  parameter int DW    = 13,
  parameter int LANES = 1,
  parameter int GROUP = 4,
  parameter int ECW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fns_dec_pipe_if.slave   bus,
  output logic [ECW-1:0]  err_cnt,
  input  logic            err_clr
);

  localparam int SW     = fns_sum_width(CW);
  localparam int NG     = CW / GROUP;
  localparam bit CFG_OK = fns_cfg_ok(CW, GROUP, DW);

  if (!CFG_OK) begin : g_cfg_check
    $error("fns_dec_pipe: CW must be >= 2 and a multiple of GROUP, DW must be >= 1");
  end

  function automatic logic [ECW-1:0] sat_add(input logic [ECW-1:0] cnt,
                                             input logic [LANES-1:0] flags);
    logic [ECW-1:0] r;
    r = cnt;
    for (int k = 0; k < LANES; k++) begin
      if (flags[k] && (r != '1)) r = r + 1'b1;
    end
    return r;
  endfunction

  logic [SW-1:0]        psum_p0   [LANES*NG];
  logic [SW-1:0]        psum_p1_d [LANES*NG];
  logic [SW-1:0]        psum_p1_q [LANES*NG];
  logic [SW-1:0]        total_p1  [LANES];
  logic [LANES*DW-1:0]  data_p1;
  logic [LANES-1:0]     err_p1;
  logic                 vld_p1_d, vld_p1_q;
  logic                 vld_p2_d, vld_p2_q;
  logic [LANES*DW-1:0]  data_p2_d, data_p2_q;
  logic [LANES-1:0]     err_p2_d, err_p2_q;
  logic [ECW-1:0]       err_cnt_d, err_cnt_q;
  logic                 in_ready, in_fire, out_fire, s2_load;

  // ---- S0: per-group weighted sums straight off the input bus
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar g = 0; g < NG; g++) begin : g_grp
      fns_partial_sum #(
        .GROUP (GROUP),
        .BASE  (g * GROUP),
        .SW    (SW)
      ) u_psum (
        .bits  (bus.codein[l*CW + g*GROUP +: GROUP]),
        .psum  (psum_p0[l*NG + g])
      );
    end
  end

  // ---- S1 -> S2: lane totals and overflow detection
  always_comb begin
    data_p1 = '0;
    for (int l = 0; l < LANES; l++) begin
      total_p1[l] = '0;
      for (int g = 0; g < NG; g++) total_p1[l] = total_p1[l] + psum_p1_q[l*NG + g];
      data_p1[l*DW +: DW] = DW'(total_p1[l]);
    end
  end

  if (DW < SW) begin : g_err
    always_comb begin
      err_p1 = '0;
      for (int l = 0; l < LANES; l++) err_p1[l] = |total_p1[l][SW-1:DW];
    end
  end else begin : g_no_err
    assign err_p1 = '0;
  end

  // S2 may refill in the same cycle it drains, which keeps a full pipe at 1 beat/clk.
  always_comb begin
    s2_load   = !vld_p2_q || bus.out_ready;
    in_ready  = !vld_p1_q || s2_load;
    in_fire   = bus.in_valid && in_ready;
    out_fire  = vld_p2_q && bus.out_ready;
    vld_p1_d  = in_fire || (vld_p1_q && !s2_load);
    vld_p2_d  = s2_load ? vld_p1_q : vld_p2_q;
    data_p2_d = data_p2_q;
    err_p2_d  = err_p2_q;
    if (s2_load && vld_p1_q) begin
      data_p2_d = data_p1;
      err_p2_d  = err_p1;
    end
    for (int i = 0; i < LANES*NG; i++) psum_p1_d[i] = in_fire ? psum_p0[i] : psum_p1_q[i];
    err_cnt_d = err_cnt_q;
    if (err_clr)       err_cnt_d = '0;
    else if (out_fire) err_cnt_d = sat_add(err_cnt_q, err_p2_q);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES*NG; i++) psum_p1_q[i] <= psum_p1_d[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      err_p2_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      err_p2_q  <= err_p2_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2_q;
  assign bus.dataout   = data_p2_q;
  assign bus.out_err   = err_p2_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_fns_dec_pipe.sv
// Scoreboard bench for fns_dec_pipe: a single-lane DW=13 instance and a three-lane DW=12 instance.
module tb_fns_dec_pipe;

  typedef struct packed {
    logic [35:0] d;
    logic [2:0]  e;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] cnt_a, cnt_b;
  logic        clr_a, clr_b;
  logic        rnd_en;
  int          n_chk, n_pass;
  int          mdl_a, mdl_b;
  beat_t       qa[$];
  beat_t       qb[$];
  logic [15:0] bp [5];
  logic [12:0] hold_a;
  beat_t       tmp;
  int          k;

  fns_dec_pipe_if #(.LANES(1), .CW(16), .DW(13)) ifa ();
  fns_dec_pipe_if #(.LANES(3), .CW(16), .DW(12)) ifb ();

  fns_dec_pipe #(.CW(16), .DW(13), .LANES(1), .GROUP(4), .ECW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .err_cnt(cnt_a), .err_clr(clr_a));

  fns_dec_pipe #(.CW(16), .DW(12), .LANES(3), .GROUP(4), .ECW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .err_cnt(cnt_b), .err_clr(clr_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: value of a Fibonacci-numeral codeword by direct weighted summation.
  function automatic int unsigned ref_sum(input logic [15:0] c);
    int unsigned a, b, t, s;
    a = 1; b = 2; s = 0;
    for (int i = 0; i < 16; i++) begin
      if (c[i]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  function automatic beat_t exp_a(input logic [15:0] c);
    beat_t r;
    int unsigned s;
    r = '0;
    s = ref_sum(c);
    r.d[12:0] = 13'(s % 8192);
    r.e[0]    = (s >= 8192);
    return r;
  endfunction

  function automatic beat_t exp_b(input logic [47:0] c);
    beat_t r;
    int unsigned s;
    r = '0;
    for (int l = 0; l < 3; l++) begin
      s = ref_sum(c[l*16 +: 16]);
      r.d[l*12 +: 12] = 12'(s % 4096);
      r.e[l]          = (s >= 4096);
    end
    return r;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic send_a(input logic [15:0] c);
    int t;
    t = 0;
    ifa.in_valid = 1'b1;
    ifa.codein   = c;
    forever begin
      @(negedge clk);
      if (ifa.in_ready) begin
        qa.push_back(exp_a(c));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 200) begin check("send_a_timeout", 0, 1); break; end
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [47:0] c);
    int t;
    t = 0;
    ifb.in_valid = 1'b1;
    ifb.codein   = c;
    forever begin
      @(negedge clk);
      if (ifb.in_ready) begin
        qb.push_back(exp_b(c));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 200) begin check("send_b_timeout", 0, 1); break; end
    end
    ifb.in_valid = 1'b0;
  endtask

  // Monitors: pop on every output handshake; track the error counter as a running tally.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      qa.delete();
      mdl_a = 0;
    end else begin
      check("err_cnt_a", cnt_a, mdl_a);
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) check("unexpected_beat_a", 1, 0);
        else begin
          e = qa.pop_front();
          check("data_a", ifa.dataout, e.d[12:0]);
          check("err_a", ifa.out_err, e.e[0]);
          mdl_a = sat16(mdl_a + $countones(e.e[0]));
        end
      end
      if (clr_a) mdl_a = 0;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      qb.delete();
      mdl_b = 0;
    end else begin
      check("err_cnt_b", cnt_b, mdl_b);
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) check("unexpected_beat_b", 1, 0);
        else begin
          e = qb.pop_front();
          check("data_b", ifb.dataout, e.d);
          check("err_b", ifb.out_err, e.e);
          mdl_b = sat16(mdl_b + $countones(e.e));
        end
      end
      if (clr_b) mdl_b = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) begin
        ifa.out_ready = ($urandom_range(0, 2) != 0);
        ifb.out_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_pass = 0; rnd_en = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.codein = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.codein = '0; ifb.out_ready = 1'b1;
    bp = '{16'h0001, 16'h0002, 16'h0004, 16'h8000, 16'h5555};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid_a", ifa.out_valid, 0);
    check("rst_dataout_a", ifa.dataout, 0);
    check("rst_out_err_b", ifb.out_err, 0);
    check("rst_err_cnt_b", cnt_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready_a", ifa.in_ready, 1);
    check("rst_in_ready_b", ifb.in_ready, 1);
    @(posedge clk); #1;

    // Single-lane decode with two-clock latency
    send_a(16'h0001);
    check("t1_lat_early", ifa.out_valid, 0);
    @(posedge clk); #1;
    check("t1_lat_valid", ifa.out_valid, 1);
    check("t1_d_0001", ifa.dataout, 1);
    send_a(16'h8000);
    @(posedge clk); #1;
    check("t1_d_8000", ifa.dataout, 1597);
    send_a(16'hFFFF);
    @(posedge clk); #1;
    check("t1_d_ffff", ifa.dataout, 4179);
    check("t1_err_ffff", ifa.out_err, 0);
    repeat (3) @(posedge clk); #1;

    // DW=12 overflow on lane 0 of the three-lane instance
    send_b({32'h0, 16'hFFFF});
    @(posedge clk); #1;
    check("t2_d_ffff", ifb.dataout[11:0], 83);
    check("t2_err_ffff", ifb.out_err, 3'b001);
    @(posedge clk); #1;
    check("t2_err_cnt", cnt_b, 1);
    send_b({32'h0, 16'h0AAA});
    @(posedge clk); #1;
    check("t2_d_0aaa", ifb.dataout[11:0], ref_sum(16'h0AAA) % 4096);
    check("t2_err_0aaa", ifb.out_err, 0);
    repeat (3) @(posedge clk); #1;

    // Three lanes in one beat
    send_b({16'hFFFF, 16'h0000, 16'h0003});
    @(posedge clk); #1;
    check("t4_dataout", ifb.dataout, {12'd83, 12'd0, 12'd3});
    check("t4_out_err", ifb.out_err, 3'b100);
    repeat (3) @(posedge clk); #1;

    // Backpressure: only two beats fit while the sink stalls
    ifa.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      ifa.in_valid = 1'b1;
      ifa.codein   = bp[k];
      @(negedge clk);
      if (ifa.in_ready) begin
        qa.push_back(exp_a(bp[k]));
        k++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready", ifa.in_ready, 0);
    check("bp_out_valid", ifa.out_valid, 1);
    tmp = exp_a(bp[0]);
    check("bp_head", ifa.dataout, tmp.d[12:0]);
    hold_a = ifa.dataout;
    ifa.codein = bp[k];
    repeat (2) @(posedge clk); #1;
    check("bp_hold", ifa.dataout, hold_a);
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    while (k < 5) begin
      send_a(bp[k]);
      k++;
    end
    repeat (4) @(posedge clk); #1;
    check("bp_drained", qa.size(), 0);

    // Random traffic with random sink stalls
    rnd_en = 1'b1;
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_a(16'($urandom));
    end
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_b({16'($urandom), 16'($urandom), 16'($urandom)});
    end
    rnd_en = 1'b0;
    @(posedge clk); #2;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rnd_drained_a", qa.size(), 0);
    check("rnd_drained_b", qb.size(), 0);

    // Reset with two beats in flight
    send_b({16'h0, 16'h0, 16'hFFFF});
    send_b({16'h0, 16'h0, 16'hFFFF});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", ifb.out_valid, 0);
    check("mid_rst_dataout", ifb.dataout, 0);
    check("mid_rst_out_err", ifb.out_err, 0);
    check("mid_rst_err_cnt", cnt_b, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", ifb.in_ready, 1);
    repeat (4) @(posedge clk); #1;
    check("post_rst_no_beat", ifb.out_valid, 0);

    // Counter saturation, then clear colliding with an error handshake
    repeat (21850) send_b({48{1'b1}});
    repeat (3) @(posedge clk); #1;
    check("sat_err_cnt", cnt_b, 65535);
    send_b({48{1'b1}});
    send_b({48{1'b1}});
    clr_b = 1'b1;
    send_b({48{1'b1}});
    clr_b = 1'b0;
    check("clr_wins", cnt_b, 0);
    repeat (4) @(posedge clk); #1;
    check("final_drained_b", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
